// File: rtl/l1c_inst_refill_master_if.sv
// l1c_inst_refill_master_if: cache refill port plus AXI4 AR/R channels of master M0
interface l1c_inst_refill_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              I_req;
  logic [ADDR_W-1:0] I_addr;
  logic [DATA_W-1:0] I_out;
  logic              I_wait;
  logic              rvalid_m0;
  logic              rready_m0;
  logic              refill_err;
  logic [ID_W-1:0]   ARID_M0;
  logic [ADDR_W-1:0] ARADDR_M0;
  logic [7:0]        ARLEN_M0;
  logic [2:0]        ARSIZE_M0;
  logic [1:0]        ARBURST_M0;
  logic              ARVALID_M0;
  logic              ARREADY_M0;
  logic [ID_W-1:0]   RID_M0;
  logic [DATA_W-1:0] RDATA_M0;
  logic [1:0]        RRESP_M0;
  logic              RLAST_M0;
  logic              RVALID_M0;
  logic              RREADY_M0;
  modport master (
    input  I_req, I_addr, ARREADY_M0, RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
    output I_out, I_wait, rvalid_m0, rready_m0, refill_err,
           ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, ARVALID_M0, RREADY_M0
  );
  modport slave (
    output I_req, I_addr, ARREADY_M0, RID_M0, RDATA_M0, RRESP_M0, RLAST_M0, RVALID_M0,
    input  I_out, I_wait, rvalid_m0, rready_m0, refill_err,
           ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, ARVALID_M0, RREADY_M0
  );
endinterface

// File: rtl/l1c_inst_refill_master.sv
// l1c_inst_refill_master: AXI4 read-burst master fetching one I-cache line per refill request
module l1c_inst_refill_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int AR_ID  = 0,
  parameter int BEATS  = 4
) (
  input logic clk,
  input logic rst,
  l1c_inst_refill_master_if.master bus
);
  localparam int CW = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS * DATA_W / 8 - 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              hs, last_beat;
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    hs        = (state_q == DATA) && bus.RVALID_M0;
    last_beat = cnt_q == CW'(BEATS - 1);
    case (state_q)
      IDLE: if (bus.I_req) begin
        araddr_d = bus.I_addr & LINE_MASK;
        state_d  = ADDR;
      end
      ADDR: if (bus.ARREADY_M0) begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: if (hs) begin
        cnt_d = cnt_q + CW'(1);
        // RLAST must coincide exactly with the final counted beat; the beat is forwarded regardless
        err_d = err_q | (bus.RRESP_M0 != 2'b00) | (bus.RID_M0 != ID_W'(AR_ID)) | (bus.RLAST_M0 != last_beat);
        state_d = bus.RLAST_M0 ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
  assign bus.ARID_M0    = ID_W'(AR_ID);
  assign bus.ARADDR_M0  = araddr_q;
  assign bus.ARLEN_M0   = 8'(BEATS - 1);
  assign bus.ARSIZE_M0  = 3'b010;
  assign bus.ARBURST_M0 = 2'b01;
  assign bus.ARVALID_M0 = state_q == ADDR;
  assign bus.RREADY_M0  = state_q == DATA;
  assign bus.rready_m0  = state_q == DATA;
  assign bus.rvalid_m0  = hs;
  assign bus.I_out      = bus.RDATA_M0;
  // busy is visible in the request cycle itself, and drops in DONE while the cache still holds I_req
  assign bus.I_wait     = (state_q == IDLE) ? bus.I_req : (state_q != DONE);
  assign bus.refill_err = err_q;
endmodule

// File: tb/tb_l1c_inst_refill_master.sv
// tb_l1c_inst_refill_master: directed refills with a scoreboard queue checked by a beat monitor
module tb_l1c_inst_refill_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  l1c_inst_refill_master_if bus ();
  l1c_inst_refill_master dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_bad = 0;
  bit done = 1'b0;
  string tst = "reset";
  logic [31:0] exp_q[$];
  logic [31:0] bd[6];
  logic [1:0]  br[6];
  logic        bl[6];
  logic [3:0]  bid[6];
  int          bg[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h", tst, name, act, exp);
    end
  endtask
  task automatic clean(input logic [31:0] base);
    for (int i = 0; i < 6; i++) begin
      bd[i] = base + 32'(i);
      br[i] = 2'b00;
      bl[i] = (i == 3);
      bid[i] = 4'd0;
      bg[i] = 0;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared", 32'(bus.refill_err), 0);
  endtask
  task automatic burst(input logic [31:0] addr, input int ar_dly, input int nb, input logic exp_err);
    bus.I_req = 1'b1;
    bus.I_addr = addr;
    #1;
    chk("wait_in_req_cycle", 32'(bus.I_wait), 1);
    @(posedge clk); #1;
    bus.I_addr = ~addr;
    chk("arlen", 32'(bus.ARLEN_M0), 3);
    chk("arsize", 32'(bus.ARSIZE_M0), 2);
    chk("arburst", 32'(bus.ARBURST_M0), 1);
    chk("arid", 32'(bus.ARID_M0), 0);
    for (int c = 0; c <= ar_dly; c++) begin
      chk("arvalid", 32'(bus.ARVALID_M0), 1);
      chk("araddr", bus.ARADDR_M0, addr & 32'hFFFF_FFF0);
      chk("rready_before_ar", 32'(bus.RREADY_M0), 0);
      chk("wait_addr", 32'(bus.I_wait), 1);
      bus.ARREADY_M0 = (c == ar_dly);
      @(posedge clk); #1;
    end
    bus.ARREADY_M0 = 1'b0;
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; g < bg[i]; g++) begin
        bus.RVALID_M0 = 1'b0;
        bus.RDATA_M0 = 32'hDEAD_0000 + 32'(g);
        chk("rready_gap", 32'(bus.RREADY_M0), 1);
        chk("wait_gap", 32'(bus.I_wait), 1);
        @(posedge clk); #1;
      end
      bus.RVALID_M0 = 1'b1;
      bus.RDATA_M0 = bd[i];
      bus.RRESP_M0 = br[i];
      bus.RLAST_M0 = bl[i];
      bus.RID_M0 = bid[i];
      exp_q.push_back(bd[i]);
      chk("rready_beat", 32'(bus.rready_m0), 1);
      @(posedge clk); #1;
    end
    bus.RVALID_M0 = 1'b0;
    bus.RLAST_M0 = 1'b0;
    bus.RRESP_M0 = 2'b00;
    bus.RID_M0 = 4'd0;
    chk("wait_done", 32'(bus.I_wait), 0);
    chk("rready_done", 32'(bus.RREADY_M0), 0);
    chk("arvalid_done", 32'(bus.ARVALID_M0), 0);
    bus.I_req = 1'b0;
    @(posedge clk); #1;
    chk("wait_idle", 32'(bus.I_wait), 0);
    chk("arvalid_idle", 32'(bus.ARVALID_M0), 0);
    chk("refill_err", 32'(bus.refill_err), 32'(exp_err));
    chk("beats_drained", 32'(exp_q.size()), 0);
  endtask
  initial begin
    bus.I_req = 1'b0;
    bus.I_addr = '0;
    bus.ARREADY_M0 = 1'b0;
    bus.RID_M0 = '0;
    bus.RDATA_M0 = '0;
    bus.RRESP_M0 = 2'b00;
    bus.RLAST_M0 = 1'b0;
    bus.RVALID_M0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("i_wait", 32'(bus.I_wait), 0);
    chk("arvalid", 32'(bus.ARVALID_M0), 0);
    chk("rready", 32'(bus.RREADY_M0), 0);
    chk("rvalid_m0", 32'(bus.rvalid_m0), 0);
    chk("araddr", bus.ARADDR_M0, 0);
    chk("refill_err", 32'(bus.refill_err), 0);
    rst = 1'b0;
    fork
      while (!done) begin
        @(negedge clk);
        if (bus.rvalid_m0 && bus.rready_m0) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s/beat: unexpected beat %h, none expected", tst, bus.I_out);
          end else begin
            chk("beat_data", bus.I_out, exp_q.pop_front());
          end
        end
      end
      begin
        tst = "basic";
        clean(32'hA0);
        burst(32'h0000_1238, 0, 4, 1'b0);
        tst = "ar_delay";
        clean(32'hB0);
        burst(32'h0000_40FC, 5, 4, 1'b0);
        tst = "r_gaps";
        clean(32'h1111_0000);
        bg[0] = 1; bg[1] = 1; bg[2] = 0; bg[3] = 2;
        burst(32'h8000_0004, 1, 4, 1'b0);
        tst = "mid_reset";
        clean(32'hC0);
        bus.I_req = 1'b1;
        bus.I_addr = 32'h0000_2000;
        @(posedge clk); #1;
        bus.ARREADY_M0 = 1'b1;
        @(posedge clk); #1;
        bus.ARREADY_M0 = 1'b0;
        bus.RVALID_M0 = 1'b1;
        bus.RDATA_M0 = bd[0];
        exp_q.push_back(bd[0]);
        @(posedge clk); #1;
        bus.RDATA_M0 = bd[1];
        exp_q.push_back(bd[1]);
        rst = 1'b1;
        bus.I_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rvalid_idle", 32'(bus.rvalid_m0), 0);
        chk("rready", 32'(bus.RREADY_M0), 0);
        chk("arvalid", 32'(bus.ARVALID_M0), 0);
        chk("i_wait", 32'(bus.I_wait), 0);
        chk("refill_err", 32'(bus.refill_err), 0);
        @(posedge clk); #1;
        bus.RVALID_M0 = 1'b0;
        clean(32'hC8);
        burst(32'h0000_2010, 0, 4, 1'b0);
        tst = "bad_rid";
        clean(32'hD0);
        bid[2] = 4'd5;
        burst(32'h0000_3000, 0, 4, 1'b1);
        do_reset();
        tst = "missing_rlast";
        clean(32'hE0);
        bl[3] = 1'b0;
        bl[4] = 1'b1;
        burst(32'h0000_3100, 0, 5, 1'b1);
        do_reset();
        tst = "early_rlast";
        clean(32'hF0);
        bl[0] = 1'b1;
        burst(32'h0000_3200, 0, 1, 1'b1);
        do_reset();
        clean(32'hF8);
        burst(32'h0000_3210, 0, 4, 1'b0);
        tst = "rresp_err";
        clean(32'h50);
        br[1] = 2'b10;
        burst(32'h0000_5000, 0, 4, 1'b1);
        tst = "sticky_err";
        clean(32'h60);
        burst(32'h0000_6000, 0, 4, 1'b1);
        do_reset();
        done = 1'b1;
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
